// File: rtl/qtu_neighbor_table.sv
// Neighbour / known-cluster-head table updater: one en pulse scans for the packet source,
// updates or inserts it, then records the advertised cluster head if it is new.
module qtu_neighbor_table #(
    parameter int WORD_WIDTH = 16,
    parameter int MAX_NEIGHBORS = 16,
    parameter int MAX_CH = 8,
    parameter logic [2:0] PKT_DATA = 3'b101,
    localparam int NW = $clog2(MAX_NEIGHBORS),
    localparam int CW = $clog2(MAX_CH)
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  en,
    input  logic [WORD_WIDTH-1:0] fSourceID,
    input  logic [WORD_WIDTH-1:0] fSourceHops,
    input  logic [WORD_WIDTH-1:0] fEnergyLeft,
    input  logic [WORD_WIDTH-1:0] fQValue,
    input  logic [WORD_WIDTH-1:0] fKnownCH,
    input  logic [2:0]            fPacketType,
    input  logic [NW-1:0]         rd_index,
    output logic [WORD_WIDTH-1:0] rd_id,
    output logic [WORD_WIDTH-1:0] rd_hops,
    output logic [WORD_WIDTH-1:0] rd_energy,
    output logic [WORD_WIDTH-1:0] rd_qvalue,
    input  logic [CW-1:0]         rd_ch_index,
    output logic [WORD_WIDTH-1:0] rd_ch,
    output logic [WORD_WIDTH-1:0] neighborCount,
    output logic [WORD_WIDTH-1:0] knownCHCount,
    output logic                  hit,
    output logic [NW-1:0]         hit_index,
    output logic                  busy,
    output logic                  done,
    output logic                  nb_overflow,
    output logic                  ch_overflow
);

    typedef enum logic [2:0] {IDLE, SCAN, UPD, INS, CHSCAN, CHINS, DONE} state_t;

    state_t state, next_state;

    logic [WORD_WIDTH-1:0] nb_id     [MAX_NEIGHBORS];
    logic [WORD_WIDTH-1:0] nb_hops   [MAX_NEIGHBORS];
    logic [WORD_WIDTH-1:0] nb_energy [MAX_NEIGHBORS];
    logic [WORD_WIDTH-1:0] nb_q      [MAX_NEIGHBORS];
    logic [WORD_WIDTH-1:0] ch_list   [MAX_CH];

    logic [WORD_WIDTH-1:0] src_id, src_hops, src_energy, src_q, src_ch;
    logic                  pkt_valid;
    logic [WORD_WIDTH-1:0] scan_idx;

    logic nb_end, nb_match, ch_end, ch_match;

    // Both scans share one index; it restarts at 0 before the CH scan.
    assign nb_end   = (scan_idx == neighborCount);
    assign nb_match = (nb_id[scan_idx[NW-1:0]] == src_id);
    assign ch_end   = (scan_idx == knownCHCount);
    assign ch_match = (ch_list[scan_idx[CW-1:0]] == src_ch);

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) state <= IDLE;
        else      state <= next_state;
    end

    // Invalid packets are filtered on the first SCAN cycle, once the fields are latched.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (en) next_state = SCAN;
            SCAN: begin
                if (!pkt_valid)    next_state = DONE;
                else if (nb_end)   next_state = INS;
                else if (nb_match) next_state = UPD;
            end
            UPD, INS: next_state = (src_ch == '0) ? DONE : CHSCAN;
            CHSCAN: begin
                if (ch_end)        next_state = CHINS;
                else if (ch_match) next_state = DONE;
            end
            CHINS:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            for (int i = 0; i < MAX_NEIGHBORS; i++) begin
                nb_id[i]     <= '0;
                nb_hops[i]   <= '0;
                nb_energy[i] <= '0;
                nb_q[i]      <= '0;
            end
            for (int i = 0; i < MAX_CH; i++) ch_list[i] <= '0;
            src_id        <= '0;
            src_hops      <= '0;
            src_energy    <= '0;
            src_q         <= '0;
            src_ch        <= '0;
            pkt_valid     <= 1'b0;
            scan_idx      <= '0;
            neighborCount <= '0;
            knownCHCount  <= '0;
            hit           <= 1'b0;
            hit_index     <= '0;
            nb_overflow   <= 1'b0;
            ch_overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        src_id     <= fSourceID;
                        src_hops   <= fSourceHops;
                        src_energy <= fEnergyLeft;
                        src_q      <= fQValue;
                        src_ch     <= fKnownCH;
                        pkt_valid  <= (fPacketType == PKT_DATA) && (fSourceID != '0);
                    end
                    scan_idx <= '0;
                end
                SCAN: begin
                    if (!pkt_valid) hit <= 1'b0;
                    else if (!nb_end && !nb_match) scan_idx <= scan_idx + WORD_WIDTH'(1);
                end
                UPD: begin
                    nb_hops[scan_idx[NW-1:0]]   <= src_hops;
                    nb_energy[scan_idx[NW-1:0]] <= src_energy;
                    nb_q[scan_idx[NW-1:0]]      <= src_q;
                    hit       <= 1'b1;
                    hit_index <= scan_idx[NW-1:0];
                    scan_idx  <= '0;
                end
                INS: begin
                    hit <= 1'b0;
                    if (neighborCount < WORD_WIDTH'(MAX_NEIGHBORS)) begin
                        nb_id[neighborCount[NW-1:0]]     <= src_id;
                        nb_hops[neighborCount[NW-1:0]]   <= src_hops;
                        nb_energy[neighborCount[NW-1:0]] <= src_energy;
                        nb_q[neighborCount[NW-1:0]]      <= src_q;
                        hit_index     <= neighborCount[NW-1:0];
                        neighborCount <= neighborCount + WORD_WIDTH'(1);
                    end else begin
                        nb_overflow <= 1'b1;
                    end
                    scan_idx <= '0;
                end
                CHSCAN: begin
                    if (!ch_end && !ch_match) scan_idx <= scan_idx + WORD_WIDTH'(1);
                end
                CHINS: begin
                    if (knownCHCount < WORD_WIDTH'(MAX_CH)) begin
                        ch_list[knownCHCount[CW-1:0]] <= src_ch;
                        knownCHCount <= knownCHCount + WORD_WIDTH'(1);
                    end else begin
                        ch_overflow <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Entries beyond the valid count always read back as zero.
    always_comb begin
        rd_id     = '0;
        rd_hops   = '0;
        rd_energy = '0;
        rd_qvalue = '0;
        rd_ch     = '0;
        if (WORD_WIDTH'(rd_index) < neighborCount) begin
            rd_id     = nb_id[rd_index];
            rd_hops   = nb_hops[rd_index];
            rd_energy = nb_energy[rd_index];
            rd_qvalue = nb_q[rd_index];
        end
        if (WORD_WIDTH'(rd_ch_index) < knownCHCount) rd_ch = ch_list[rd_ch_index];
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_qtu_neighbor_table.sv
// Directed self-checking bench for qtu_neighbor_table: insert, update, filtering,
// overflow of both tables, en-while-busy and asynchronous reset during a scan.
module tb_qtu_neighbor_table;

    localparam int WW = 16;
    localparam int MN = 16;
    localparam int MC = 8;

    logic          clk = 1'b0;
    logic          nrst;
    logic          en;
    logic [WW-1:0] fSourceID, fSourceHops, fEnergyLeft, fQValue, fKnownCH;
    logic [2:0]    fPacketType;
    logic [3:0]    rd_index;
    logic [2:0]    rd_ch_index;
    logic [WW-1:0] rd_id, rd_hops, rd_energy, rd_qvalue, rd_ch;
    logic [WW-1:0] neighborCount, knownCHCount;
    logic          hit;
    logic [3:0]    hit_index;
    logic          busy, done, nb_overflow, ch_overflow;

    int compared = 0;
    int mismatched = 0;
    int lat;
    int doneSeen;

    always #5 clk = ~clk;

    qtu_neighbor_table #(.WORD_WIDTH(WW), .MAX_NEIGHBORS(MN), .MAX_CH(MC), .PKT_DATA(3'b101)) dut (
        .clk(clk), .nrst(nrst), .en(en),
        .fSourceID(fSourceID), .fSourceHops(fSourceHops), .fEnergyLeft(fEnergyLeft),
        .fQValue(fQValue), .fKnownCH(fKnownCH), .fPacketType(fPacketType),
        .rd_index(rd_index), .rd_id(rd_id), .rd_hops(rd_hops), .rd_energy(rd_energy),
        .rd_qvalue(rd_qvalue), .rd_ch_index(rd_ch_index), .rd_ch(rd_ch),
        .neighborCount(neighborCount), .knownCHCount(knownCHCount),
        .hit(hit), .hit_index(hit_index), .busy(busy), .done(done),
        .nb_overflow(nb_overflow), .ch_overflow(ch_overflow)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives one packet across the en edge, then scrambles the inputs to prove they were latched.
    task automatic startPacket(input logic [WW-1:0] id, hops, energy, q, ch, input logic [2:0] ptype);
        @(negedge clk);
        fSourceID = id; fSourceHops = hops; fEnergyLeft = energy;
        fQValue = q; fKnownCH = ch; fPacketType = ptype; en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        fSourceID = 16'hFFFF; fSourceHops = 16'hFFFF; fEnergyLeft = 16'hFFFF;
        fQValue = 16'hFFFF; fKnownCH = 16'hFFFF; fPacketType = 3'b000;
    endtask

    // Latency is counted as the en edge plus every edge up to the one that raised done.
    task automatic waitDone(output int latency);
        int k = 0;
        while (done !== 1'b1 && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (done === 1'b1) begin
            latency = k + 1;
        end else begin
            latency = -1;
            compared++;
            mismatched++;
            $error("[TB] FAIL done_timeout: observed no done expected done within 300 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [WW-1:0] id, hops, energy, q, ch, input logic [2:0] ptype,
                                 output int latency);
        startPacket(id, hops, energy, q, ch, ptype);
        waitDone(latency);
    endtask

    task automatic readNb(input int i);
        rd_index = 4'(i);
        #1;
    endtask

    task automatic readCh(input int i);
        rd_ch_index = 3'(i);
        #1;
    endtask

    initial begin
        nrst = 1'b1; en = 1'b0;
        fSourceID = '0; fSourceHops = '0; fEnergyLeft = '0; fQValue = '0; fKnownCH = '0;
        fPacketType = 3'b000; rd_index = '0; rd_ch_index = '0;
        repeat (2) @(negedge clk);
        nrst = 1'b0;
        #1;
        checkOutput("reset_nc", neighborCount, 0);
        checkOutput("reset_kc", knownCHCount, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_hit", hit, 0);
        checkOutput("reset_nbovf", nb_overflow, 0);
        checkOutput("reset_rdid0", rd_id, 0);

        applyStimulus(16'd1, 16'd2, 16'h0100, 16'h3000, 16'd15, 3'b101, lat);
        checkOutput("p1_latency", lat, 5);
        checkOutput("p1_nc", neighborCount, 1);
        checkOutput("p1_kc", knownCHCount, 1);
        checkOutput("p1_hit", hit, 0);
        checkOutput("p1_busy", busy, 0);
        readNb(0);
        checkOutput("p1_rdid0", rd_id, 1);
        checkOutput("p1_rdhops0", rd_hops, 2);
        checkOutput("p1_rdenergy0", rd_energy, 16'h0100);
        checkOutput("p1_rdq0", rd_qvalue, 16'h3000);
        readCh(0);
        checkOutput("p1_rdch0", rd_ch, 15);
        readCh(1);
        checkOutput("p1_rdch1_empty", rd_ch, 0);

        applyStimulus(16'd17, 16'd1, 16'h0200, 16'hB800, 16'd15, 3'b101, lat);
        checkOutput("p2_nc", neighborCount, 2);
        checkOutput("p2_kc", knownCHCount, 1);
        checkOutput("p2_hit", hit, 0);
        checkOutput("p2_hitidx", hit_index, 1);
        readNb(1);
        checkOutput("p2_rdid1", rd_id, 17);
        checkOutput("p2_rdq1", rd_qvalue, 16'hB800);

        applyStimulus(16'd1, 16'd3, 16'h0300, 16'h1800, 16'd0, 3'b101, lat);
        checkOutput("p3_latency", lat, 3);
        checkOutput("p3_hit", hit, 1);
        checkOutput("p3_hitidx", hit_index, 0);
        checkOutput("p3_nc", neighborCount, 2);
        checkOutput("p3_kc", knownCHCount, 1);
        readNb(0);
        checkOutput("p3_rdq0", rd_qvalue, 16'h1800);
        checkOutput("p3_rdhops0", rd_hops, 3);
        checkOutput("p3_rdenergy0", rd_energy, 16'h0300);

        applyStimulus(16'd50, 16'd1, 16'h0001, 16'h0001, 16'd9, 3'b001, lat);
        checkOutput("badtype_latency", lat, 2);
        checkOutput("badtype_hit", hit, 0);
        checkOutput("badtype_nc", neighborCount, 2);
        checkOutput("badtype_kc", knownCHCount, 1);
        applyStimulus(16'd0, 16'd1, 16'h0001, 16'h0001, 16'd9, 3'b101, lat);
        checkOutput("zeroid_latency", lat, 2);
        checkOutput("zeroid_nc", neighborCount, 2);
        checkOutput("zeroid_kc", knownCHCount, 1);

        startPacket(16'd60, 16'd4, 16'h0400, 16'h0400, 16'd0, 3'b101);
        @(negedge clk);
        fSourceID = 16'd61; fPacketType = 3'b101; fKnownCH = 16'd0; en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        doneSeen = 0;
        repeat (40) begin
            if (done === 1'b1) doneSeen++;
            @(posedge clk);
            #1;
        end
        checkOutput("busy_en_done_count", doneSeen, 1);
        checkOutput("busy_en_nc", neighborCount, 3);
        readNb(2);
        checkOutput("busy_en_rdid2", rd_id, 60);
        readNb(3);
        checkOutput("busy_en_rdid3_empty", rd_id, 0);

        for (int i = 0; i < 13; i++)
            applyStimulus(16'(100 + i), 16'd5, 16'h0500, 16'h0500, 16'd0, 3'b101, lat);
        checkOutput("fill_nc", neighborCount, 16);
        checkOutput("fill_hitidx", hit_index, 15);
        checkOutput("fill_nbovf_before", nb_overflow, 0);
        applyStimulus(16'd200, 16'd5, 16'h0500, 16'h0500, 16'd0, 3'b101, lat);
        checkOutput("ovf_nbovf", nb_overflow, 1);
        checkOutput("ovf_nc", neighborCount, 16);
        checkOutput("ovf_hitidx", hit_index, 15);
        checkOutput("ovf_hit", hit, 0);
        readNb(15);
        checkOutput("ovf_rdid15", rd_id, 112);
        readNb(0);
        checkOutput("ovf_rdid0", rd_id, 1);
        readNb(1);
        checkOutput("ovf_rdid1", rd_id, 17);

        for (int i = 0; i < 7; i++)
            applyStimulus(16'd1, 16'd3, 16'h0300, 16'h1800, 16'(20 + i), 3'b101, lat);
        checkOutput("chfill_kc", knownCHCount, 8);
        checkOutput("chfill_chovf_before", ch_overflow, 0);
        applyStimulus(16'd1, 16'd3, 16'h0300, 16'h1800, 16'd27, 3'b101, lat);
        checkOutput("chovf_chovf", ch_overflow, 1);
        checkOutput("chovf_kc", knownCHCount, 8);
        checkOutput("chovf_nc", neighborCount, 16);
        readCh(7);
        checkOutput("chovf_rdch7", rd_ch, 26);
        readCh(0);
        checkOutput("chovf_rdch0", rd_ch, 15);

        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        nrst = 1'b0;
        applyStimulus(16'd1, 16'd2, 16'h0100, 16'h3000, 16'd15, 3'b101, lat);
        applyStimulus(16'd17, 16'd1, 16'h0200, 16'hB800, 16'd15, 3'b101, lat);
        startPacket(16'd99, 16'd1, 16'h0100, 16'h0100, 16'd3, 3'b101);
        checkOutput("midrst_busy_before", busy, 1);
        @(negedge clk);
        nrst = 1'b1;
        readNb(0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_nc", neighborCount, 0);
        checkOutput("midrst_kc", knownCHCount, 0);
        checkOutput("midrst_rdid0", rd_id, 0);
        checkOutput("midrst_nbovf", nb_overflow, 0);
        checkOutput("midrst_chovf", ch_overflow, 0);
        @(negedge clk);
        nrst = 1'b0;
        applyStimulus(16'd5, 16'd2, 16'h0700, 16'h2000, 16'd7, 3'b101, lat);
        checkOutput("postrst_latency", lat, 5);
        checkOutput("postrst_nc", neighborCount, 1);
        checkOutput("postrst_kc", knownCHCount, 1);
        readNb(0);
        checkOutput("postrst_rdid0", rd_id, 5);
        readCh(0);
        checkOutput("postrst_rdch0", rd_ch, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
